// File: rtl/draw_game_objects_if.sv
// Pixel stream carried between overlay stages: counters, sync/blank strobes and 12-bit colour.
interface vga_intf;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_game_objects.sv
// Ball and pad overlay on the game-field stream: frame-committed positions, 2-cycle pipeline,
// and a frame-counted flash FSM that blinks the ball.
module draw_game_objects #(
    parameter int          HOR_PIXELS   = 1024,
    parameter int          VER_PIXELS   = 768,
    parameter int          PAD_WIDTH    = 15,
    parameter int          PAD_HEIGHT   = 145,
    parameter int          X_PAD_LEFT   = 30,
    parameter int          X_PAD_RIGHT  = 979,
    parameter logic [11:0] BALL_RGB     = 12'hFFF,
    parameter logic [11:0] PAD_RGB      = 12'hFFF,
    parameter logic [11:0] FLASH_RGB    = 12'hF00,
    parameter int          FLASH_PERIOD = 8,
    parameter int          FLASH_COUNT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    vga_intf.in         game_field_in,
    vga_intf.out        game_field_out,
    input  logic [10:0] x_ball,
    input  logic [10:0] y_ball,
    input  logic [10:0] y_pad_left,
    input  logic [10:0] y_pad_right,
    input  logic        pos_valid,
    input  logic        flash_req,
    output logic        flash_busy
);
    localparam logic [10:0] X_BALL_RST = 11'((HOR_PIXELS - 16) / 2);
    localparam logic [10:0] Y_BALL_RST = 11'((VER_PIXELS - 16) / 2);
    localparam logic [10:0] Y_PAD_RST  = 11'((VER_PIXELS - PAD_HEIGHT) / 2);

    localparam logic [11:0] PL_X0  = 12'(X_PAD_LEFT);
    localparam logic [11:0] PL_X1  = 12'(X_PAD_LEFT + PAD_WIDTH - 1);
    localparam logic [11:0] PR_X0  = 12'(X_PAD_RIGHT);
    localparam logic [11:0] PR_X1  = 12'(X_PAD_RIGHT + PAD_WIDTH - 1);
    localparam logic [11:0] PAD_H1 = 12'(PAD_HEIGHT - 1);

    localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int PW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_PERIOD - 1);
    localparam logic [PW-1:0] PAIR_LAST  = PW'(FLASH_COUNT - 1);

    typedef enum logic [1:0] {FL_IDLE, FL_ON, FL_OFF} flash_state_t;

    // 16x16 circle, radius 7 centred on column 7 / row 8; bit index = column.
    function automatic logic [15:0] ball_rom(input logic [3:0] row);
        case (row)
            4'd0:    ball_rom = 16'h0000;
            4'd1:    ball_rom = 16'h0080;
            4'd2:    ball_rom = 16'h07F0;
            4'd3:    ball_rom = 16'h0FF8;
            4'd4:    ball_rom = 16'h1FFC;
            4'd5:    ball_rom = 16'h3FFE;
            4'd6:    ball_rom = 16'h3FFE;
            4'd7:    ball_rom = 16'h3FFE;
            4'd8:    ball_rom = 16'h7FFF;
            4'd9:    ball_rom = 16'h3FFE;
            4'd10:   ball_rom = 16'h3FFE;
            4'd11:   ball_rom = 16'h3FFE;
            4'd12:   ball_rom = 16'h1FFC;
            4'd13:   ball_rom = 16'h0FF8;
            4'd14:   ball_rom = 16'h07F0;
            default: ball_rom = 16'h0080;
        endcase
    endfunction

    logic [10:0] x_ball_p, y_ball_p, y_pl_p, y_pr_p;
    logic [10:0] x_ball_a, y_ball_a, y_pl_a, y_pr_a;
    logic        vblnk_q;
    logic        frame_start;

    assign frame_start = game_field_in.vblnk & ~vblnk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q  <= 1'b0;
            x_ball_p <= X_BALL_RST;
            y_ball_p <= Y_BALL_RST;
            y_pl_p   <= Y_PAD_RST;
            y_pr_p   <= Y_PAD_RST;
            x_ball_a <= X_BALL_RST;
            y_ball_a <= Y_BALL_RST;
            y_pl_a   <= Y_PAD_RST;
            y_pr_a   <= Y_PAD_RST;
        end else begin
            vblnk_q <= game_field_in.vblnk;
            if (pos_valid) begin
                x_ball_p <= x_ball;
                y_ball_p <= y_ball;
                y_pl_p   <= y_pad_left;
                y_pr_p   <= y_pad_right;
            end
            // Active takes the pending value as it stood before this edge.
            if (frame_start) begin
                x_ball_a <= x_ball_p;
                y_ball_a <= y_ball_p;
                y_pl_a   <= y_pl_p;
                y_pr_a   <= y_pr_p;
            end
        end
    end

    flash_state_t         state;
    logic [FW-1:0]        frame_cnt;
    logic [PW-1:0]        pair_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FL_IDLE;
            frame_cnt  <= '0;
            pair_cnt   <= '0;
            flash_busy <= 1'b0;
        end else if (flash_req) begin
            state      <= FL_ON;
            frame_cnt  <= '0;
            pair_cnt   <= '0;
            flash_busy <= 1'b1;
        end else if (frame_start) begin
            case (state)
                FL_ON: begin
                    if (frame_cnt == FRAME_LAST) begin
                        state     <= FL_OFF;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                FL_OFF: begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        if (pair_cnt != PAIR_LAST) begin
                            state    <= FL_ON;
                            pair_cnt <= pair_cnt + 1'b1;
                        end else begin
                            state      <= FL_IDLE;
                            flash_busy <= 1'b0;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hit tests are 12 bits wide so boxes near the 11-bit limit clip instead of wrapping.
    logic [11:0] hc, vc, xb, yb, ypl, ypr;
    logic        in_box, pad_hit;

    assign hc  = {1'b0, game_field_in.hcount};
    assign vc  = {1'b0, game_field_in.vcount};
    assign xb  = {1'b0, x_ball_a};
    assign yb  = {1'b0, y_ball_a};
    assign ypl = {1'b0, y_pl_a};
    assign ypr = {1'b0, y_pr_a};

    assign in_box  = (hc >= xb) && (hc <= xb + 12'd15) && (vc >= yb) && (vc <= yb + 12'd15);
    assign pad_hit = ((hc >= PL_X0) && (hc <= PL_X1) && (vc >= ypl) && (vc <= ypl + PAD_H1)) ||
                     ((hc >= PR_X0) && (hc <= PR_X1) && (vc >= ypr) && (vc <= ypr + PAD_H1));

    logic        s1_in_box, s1_pad, s1_blank, s1_ball_en;
    logic [3:0]  s1_row, s1_col;
    logic [11:0] s1_rgb, s1_ball_rgb, rgb_q;
    logic [25:0] sync_d1, sync_d2;
    logic [15:0] rom_bits;
    logic        ball_px;

    assign rom_bits = ball_rom(s1_row);
    assign ball_px  = s1_in_box && s1_ball_en && rom_bits[s1_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_in_box   <= 1'b0;
            s1_pad      <= 1'b0;
            s1_blank    <= 1'b0;
            s1_ball_en  <= 1'b0;
            s1_row      <= '0;
            s1_col      <= '0;
            s1_rgb      <= '0;
            s1_ball_rgb <= '0;
            rgb_q       <= '0;
            sync_d1     <= '0;
            sync_d2     <= '0;
        end else begin
            s1_in_box   <= in_box;
            s1_pad      <= pad_hit;
            s1_blank    <= game_field_in.vblnk | game_field_in.hblnk;
            s1_ball_en  <= (state != FL_OFF);
            s1_ball_rgb <= (state == FL_ON) ? FLASH_RGB : BALL_RGB;
            s1_row      <= game_field_in.vcount[3:0] - y_ball_a[3:0];
            s1_col      <= game_field_in.hcount[3:0] - x_ball_a[3:0];
            s1_rgb      <= game_field_in.rgb;
            sync_d1     <= {game_field_in.vcount, game_field_in.hcount, game_field_in.vsync,
                            game_field_in.vblnk, game_field_in.hsync, game_field_in.hblnk};
            sync_d2     <= sync_d1;
            rgb_q       <= s1_blank ? 12'h000 :
                           ball_px  ? s1_ball_rgb :
                           s1_pad   ? PAD_RGB : s1_rgb;
        end
    end

    assign game_field_out.vcount = sync_d2[25:15];
    assign game_field_out.hcount = sync_d2[14:4];
    assign game_field_out.vsync  = sync_d2[3];
    assign game_field_out.vblnk  = sync_d2[2];
    assign game_field_out.hsync  = sync_d2[1];
    assign game_field_out.hblnk  = sync_d2[0];
    assign game_field_out.rgb    = rgb_q;
endmodule

// File: tb/tb_draw_game_objects.sv
// Scoreboard bench for draw_game_objects: probe pixels push hand-computed expectations, a monitor
// pops them two cycles later; reset and flash_busy are checked directly.
module tb_draw_game_objects;
    localparam logic [11:0] BG    = 12'h0A5;
    localparam logic [11:0] BALL  = 12'hFFF;
    localparam logic [11:0] PAD   = 12'hFFF;
    localparam logic [11:0] FLASH = 12'hF00;

    logic clk = 1'b0;
    logic rst;
    logic [10:0] x_ball, y_ball, y_pad_left, y_pad_right;
    logic pos_valid, flash_req, flash_busy;
    logic probe = 1'b0, probe_d1 = 1'b0, probe_d2 = 1'b0;
    int checks = 0, passed = 0;

    typedef struct packed {
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [10:0] vc;
        logic hs, vs, hb, vb;
    } pix_t;

    pix_t  sb_q[$];
    string nm_q[$];

    vga_intf gf_in();
    vga_intf gf_out();

    draw_game_objects #(.FLASH_PERIOD(2), .FLASH_COUNT(3)) dut (
        .clk(clk), .rst(rst),
        .game_field_in(gf_in), .game_field_out(gf_out),
        .x_ball(x_ball), .y_ball(y_ball), .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .pos_valid(pos_valid), .flash_req(flash_req), .flash_busy(flash_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        probe_d1 <= probe;
        probe_d2 <= probe_d1;
    end

    always @(negedge clk) begin
        if (probe_d2) begin
            pix_t act, exp_p;
            string nm;
            act = '{gf_out.rgb, gf_out.hcount, gf_out.vcount,
                    gf_out.hsync, gf_out.vsync, gf_out.hblnk, gf_out.vblnk};
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_output: got %h, scoreboard empty", act);
            end else begin
                exp_p = sb_q.pop_front();
                nm    = nm_q.pop_front();
                if (act === exp_p) passed++;
                else $display("FAIL %s: got rgb=%h h=%0d v=%0d syn=%b, want rgb=%h h=%0d v=%0d syn=%b",
                              nm, act.rgb, act.hc, act.vc, {act.hs, act.vs, act.hb, act.vb},
                              exp_p.rgb, exp_p.hc, exp_p.vc, {exp_p.hs, exp_p.vs, exp_p.hb, exp_p.vb});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp_v);
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                         input logic en);
        @(posedge clk); #1;
        gf_in.hcount = h;
        gf_in.vcount = v;
        gf_in.hsync  = h[0];
        gf_in.vsync  = v[0];
        gf_in.hblnk  = hb;
        gf_in.vblnk  = vb;
        gf_in.rgb    = BG;
        pos_valid    = 1'b0;
        flash_req    = 1'b0;
        probe        = en;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                       input logic [11:0] exp_rgb, input string nm);
        drive(h, v, hb, 1'b0, 1'b1);
        sb_q.push_back('{exp_rgb, h, v, h[0], v[0], hb, 1'b0});
        nm_q.push_back(nm);
    endtask

    task automatic frame_start();
        repeat (3) drive(11'd0, 11'd0, 1'b1, 1'b1, 1'b0);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_pos(input logic [10:0] x, input logic [10:0] y,
                           input logic [10:0] yl, input logic [10:0] yr);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        x_ball = x; y_ball = y; y_pad_left = yl; y_pad_right = yr;
        pos_valid = 1'b1;
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_flash();
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        flash_req = 1'b1;
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        pos_valid = 1'b0; flash_req = 1'b0;
        x_ball = 11'd0; y_ball = 11'd0; y_pad_left = 11'd0; y_pad_right = 11'd0;
        gf_in.hcount = 11'd5; gf_in.vcount = 11'd5; gf_in.rgb = BG;
        gf_in.hsync = 1'b1; gf_in.vsync = 1'b1; gf_in.hblnk = 1'b0; gf_in.vblnk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb", 32'(gf_out.rgb), 32'h0);
        chk("reset_sync", 32'({gf_out.hcount, gf_out.vcount, gf_out.hsync, gf_out.vsync,
                               gf_out.hblnk, gf_out.vblnk}), 32'h0);
        chk("reset_busy", 32'(flash_busy), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Defaults: ball (504,376), pads y=311
        frame_start();
        pix(11'd511, 11'd377, 1'b0, BALL, "def_ball_top");
        pix(11'd504, 11'd376, 1'b0, BG,   "def_ball_corner");
        pix(11'd511, 11'd377, 1'b1, 12'h000, "def_hblank");
        pix(11'd30,  11'd311, 1'b0, PAD,  "def_lpad_tl");
        pix(11'd44,  11'd455, 1'b0, PAD,  "def_lpad_br");
        pix(11'd45,  11'd311, 1'b0, BG,   "def_lpad_right_out");
        pix(11'd30,  11'd310, 1'b0, BG,   "def_lpad_above");
        pix(11'd993, 11'd400, 1'b0, PAD,  "def_rpad_edge");
        pix(11'd994, 11'd400, 1'b0, BG,   "def_rpad_out");

        // Mid-frame update only takes effect after the next frame start
        set_pos(11'd100, 11'd50, 11'd311, 11'd311);
        pix(11'd511, 11'd377, 1'b0, BALL, "pend_old_ball");
        pix(11'd107, 11'd51,  1'b0, BG,   "pend_new_not_yet");
        frame_start();
        pix(11'd107, 11'd51,  1'b0, BALL, "new_ball_top");
        pix(11'd100, 11'd50,  1'b0, BG,   "new_ball_corner");
        pix(11'd511, 11'd377, 1'b0, BG,   "old_ball_gone");
        pix(11'd100, 11'd58,  1'b0, BALL, "new_ball_col0");
        pix(11'd114, 11'd58,  1'b0, BALL, "new_ball_col14");
        pix(11'd115, 11'd58,  1'b0, BG,   "new_ball_col15");

        // Edge of screen and 11-bit wrap
        set_pos(11'd1020, 11'd760, 11'd311, 11'd311);
        frame_start();
        pix(11'd1023, 11'd767, 1'b0, BALL, "edge_r7c3");
        pix(11'd1020, 11'd760, 1'b0, BG,   "edge_row0");
        pix(11'd1021, 11'd764, 1'b0, BG,   "edge_r4c1");
        pix(11'd3,    11'd7,   1'b0, BG,   "edge_no_wrap_lo");
        set_pos(11'd2040, 11'd100, 11'd311, 11'd311);
        frame_start();
        pix(11'd2047, 11'd108, 1'b0, BALL, "wrap_r8c7");
        pix(11'd3,    11'd108, 1'b0, BG,   "wrap_clip_x3");

        // Ball over left pad
        set_pos(11'd36, 11'd40, 11'd40, 11'd311);
        frame_start();
        pix(11'd43, 11'd48,  1'b0, BALL, "ovl_ball");
        pix(11'd36, 11'd40,  1'b0, PAD,  "ovl_corner_pad");
        pix(11'd36, 11'd41,  1'b0, PAD,  "ovl_r1c0_pad");
        pix(11'd30, 11'd40,  1'b0, PAD,  "ovl_pad_tl");
        pix(11'd44, 11'd184, 1'b0, PAD,  "ovl_pad_br");
        pix(11'd44, 11'd185, 1'b0, BG,   "ovl_pad_below");
        pix(11'd43, 11'd48,  1'b1, 12'h000, "ovl_blank");

        // Flash: period 2, count 3
        set_pos(11'd200, 11'd200, 11'd311, 11'd311);
        frame_start();
        pix(11'd207, 11'd208, 1'b0, BALL, "flash_pre");
        pulse_flash();
        for (int f = 1; f <= 13; f++) begin
            logic [11:0] e;
            if (f == 13) e = BALL;
            else e = ((((f - 1) / 2) % 2) == 0) ? FLASH : BG;
            pix(11'd207, 11'd208, 1'b0, e, $sformatf("flash_frame%0d", f));
            @(negedge clk);
            chk($sformatf("flash_busy_frame%0d", f), 32'(flash_busy), (f <= 12) ? 32'h1 : 32'h0);
            frame_start();
        end

        // Asynchronous reset during an ON phase
        pulse_flash();
        repeat (3) drive(11'd207, 11'd208, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_flash_rgb", 32'(gf_out.rgb), 32'(FLASH));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rgb", 32'(gf_out.rgb), 32'h0);
        chk("async_rst_busy", 32'(flash_busy), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        frame_start();
        pix(11'd511, 11'd377, 1'b0, BALL, "post_rst_ball");
        pix(11'd504, 11'd376, 1'b0, BG,   "post_rst_corner");
        pix(11'd30,  11'd311, 1'b0, PAD,  "post_rst_pad");
        pix(11'd207, 11'd208, 1'b0, BG,   "post_rst_old_pos");

        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
